// File: rtl/gearbox_serializer_pkg.sv
// -----------------------------------------------------------------------------
// gearbox_serializer_pkg
// Shared types and helpers for the gearbox serializer:
//   ser_state_e  - serializer FSM state (IDLE, SHIFT)
//   beat_cnt_w() - width of the beat counter for a given beat count
// -----------------------------------------------------------------------------
package gearbox_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Wide enough to also hold the value BEATS, which indexes the optional
  // parity beat.
  function automatic int beat_cnt_w(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// -----------------------------------------------------------------------------
// ser_hold_reg
// One-entry holding register sitting in front of the serializer shift stage.
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   valid_i / ready_o  - upstream handshake (ready_o = register empty)
//   data_i             - incoming entry
//   bypass_i           - the accepted entry goes straight to the shifter,
//                        so it must not be stored here
//   take_i             - the shifter consumes the stored entry this edge
//   full_o / data_o    - stored entry available for loading, and its value
// -----------------------------------------------------------------------------
module ser_hold_reg #(
  parameter int DW = 17
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  input  logic          bypass_i,
  input  logic          take_i,
  output logic          full_o,
  output logic [DW-1:0] data_o
);

  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;
  logic          store;

  assign ready_o = !full_q;
  assign store   = valid_i && !full_q && !bypass_i;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    // A take and a store on the same edge leave the register full with
    // the new entry.
    if (take_i) begin
      full_d = 1'b0;
    end
    if (store) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/gearbox_serializer.sv
// -----------------------------------------------------------------------------
// gearbox_serializer
// Serializes WORD_W-bit words onto LANES serial lanes, BEATS = WORD_W/LANES
// beats per word, MSB-first or LSB-first per word. A one-entry holding
// register plus the shift stage allow back-to-back words with no gap.
// Optional feature (macro GEARBOX_SER_PARITY_EN): one extra beat per word
// carrying per-lane even parity of the bits sent on each lane.
// Ports:
//   CLK, RESET_N  - clock, asynchronous active-low reset
//   PAR_IN        - word to serialize (sampled with MSB_FIRST on accept)
//   MSB_FIRST     - bit order for the accepted word
//   IN_VALID      - PAR_IN / MSB_FIRST valid
//   IN_READY      - holding register empty, a word can be accepted
//   SERIAL_OUT    - current beat (0 when idle)
//   OUT_VALID     - SERIAL_OUT carries a data or parity beat
//   FRAME         - high on beat 0 of each word
// -----------------------------------------------------------------------------
module gearbox_serializer
  import gearbox_serializer_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int LANES  = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [WORD_W-1:0] PAR_IN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              MSB_FIRST,
  output logic [LANES-1:0]  SERIAL_OUT,
  output logic              OUT_VALID,
  output logic              FRAME
);

  localparam int BEATS = WORD_W / LANES;
  localparam int CNT_W = beat_cnt_w(BEATS);
`ifdef GEARBOX_SER_PARITY_EN
  localparam int LAST_BEAT = BEATS;
`else
  localparam int LAST_BEAT = BEATS - 1;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_BEAT);

  if ((WORD_W % LANES) != 0 || BEATS < 2) begin : g_bad_cfg
    $error("gearbox_serializer: WORD_W must be a multiple of LANES with at least 2 beats");
  end

  ser_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   sh_q, sh_d;
  logic                msb_q, msb_d;
`ifdef GEARBOX_SER_PARITY_EN
  logic [LANES-1:0]    par_q, par_d;
`endif

  logic                accept;
  logic                hold_full;
  logic [WORD_W:0]     hold_data;
  logic                load_evt;
  logic                hold_bypass;
  logic                hold_take;
  logic [LANES-1:0]    data_beat;

  assign accept = IN_VALID && IN_READY;

  // A word can enter the shifter either from idle or on the edge that ends
  // the last beat of the current word.
  assign load_evt    = (state_q == IDLE) || (cnt_q == LAST_CNT);
  assign hold_bypass = load_evt && !hold_full;
  assign hold_take   = load_evt && hold_full;

  ser_hold_reg #(
    .DW (WORD_W + 1)
  ) u_hold (
    .clk_i    (CLK),
    .rst_ni   (RESET_N),
    .valid_i  (IN_VALID),
    .ready_o  (IN_READY),
    .data_i   ({MSB_FIRST, PAR_IN}),
    .bypass_i (hold_bypass),
    .take_i   (hold_take),
    .full_o   (hold_full),
    .data_o   (hold_data)
  );

  // The shifter always presents the current beat at a fixed end: the top
  // lanes for MSB-first words, the bottom lanes for LSB-first words.
  assign data_beat = msb_q ? sh_q[WORD_W-1 -: LANES] : sh_q[LANES-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    msb_d   = msb_q;
`ifdef GEARBOX_SER_PARITY_EN
    par_d   = par_q;
`endif
    if (load_evt) begin
      cnt_d = '0;
      if (hold_full || accept) begin
        state_d = SHIFT;
        // The holding register is older than anything on the input.
        if (hold_full) begin
          sh_d  = hold_data[WORD_W-1:0];
          msb_d = hold_data[WORD_W];
        end else begin
          sh_d  = PAR_IN;
          msb_d = MSB_FIRST;
        end
`ifdef GEARBOX_SER_PARITY_EN
        par_d = '0;
`endif
      end else begin
        state_d = IDLE;
      end
    end else begin
      // Only data beats reach here; the parity beat is always a load edge.
      cnt_d = cnt_q + CNT_W'(1);
      sh_d  = msb_q ? (sh_q << LANES) : (sh_q >> LANES);
`ifdef GEARBOX_SER_PARITY_EN
      par_d = par_q ^ data_beat;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      msb_q   <= 1'b0;
`ifdef GEARBOX_SER_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      msb_q   <= msb_d;
`ifdef GEARBOX_SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign OUT_VALID = (state_q == SHIFT);
  assign FRAME     = (state_q == SHIFT) && (cnt_q == '0);

  always_comb begin
    SERIAL_OUT = '0;
    if (state_q == SHIFT) begin
`ifdef GEARBOX_SER_PARITY_EN
      SERIAL_OUT = (cnt_q == LAST_CNT) ? par_q : data_beat;
`else
      SERIAL_OUT = data_beat;
`endif
    end
  end

endmodule

// File: tb/tb_gearbox_serializer.sv
// -----------------------------------------------------------------------------
// tb_gearbox_serializer
// Directed bench for gearbox_serializer with WORD_W=8, LANES=2 (4 beats).
// Optional feature under GEARBOX_SER_PARITY_EN adds the parity beat checks.
// -----------------------------------------------------------------------------
module tb_gearbox_serializer;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] PAR_IN;
  logic       IN_VALID;
  logic       IN_READY;
  logic       MSB_FIRST;
  logic [1:0] SERIAL_OUT;
  logic       OUT_VALID;
  logic       FRAME;

  int checks   = 0;
  int failures = 0;

  gearbox_serializer #(
    .WORD_W (8),
    .LANES  (2)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .PAR_IN     (PAR_IN),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .MSB_FIRST  (MSB_FIRST),
    .SERIAL_OUT (SERIAL_OUT),
    .OUT_VALID  (OUT_VALID),
    .FRAME      (FRAME)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] ser, input logic frm);
    chk({tag, ".ser"},   {30'b0, SERIAL_OUT}, {30'b0, ser});
    chk({tag, ".vld"},   {31'b0, OUT_VALID},  32'd1);
    chk({tag, ".frame"}, {31'b0, FRAME},      {31'b0, frm});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ser"},   {30'b0, SERIAL_OUT}, 32'd0);
    chk({tag, ".vld"},   {31'b0, OUT_VALID},  32'd0);
    chk({tag, ".frame"}, {31'b0, FRAME},      32'd0);
  endtask

  initial begin
    RESET_N   = 1'b0;
    PAR_IN    = 8'h00;
    IN_VALID  = 1'b0;
    MSB_FIRST = 1'b0;

    // ---- reset state ----
    repeat (2) tick();
    chk_idle("rst");
    chk("rst.ready", {31'b0, IN_READY}, 32'd1);
    RESET_N = 1'b1;
    tick();
    chk_idle("post_rst");

    // ---- B4 MSB-first: 10 11 01 00 ----
    PAR_IN = 8'hB4; MSB_FIRST = 1'b1; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0; PAR_IN = 8'hFF; MSB_FIRST = 1'b0;
    chk_beat("msb_b0", 2'b10, 1'b1);
    tick(); chk_beat("msb_b1", 2'b11, 1'b0);
    tick(); chk_beat("msb_b2", 2'b01, 1'b0);
    tick(); chk_beat("msb_b3", 2'b00, 1'b0);
`ifdef GEARBOX_SER_PARITY_EN
    tick(); chk_beat("msb_par", 2'b00, 1'b0);
`endif
    // ---- idle for 10 cycles after the last beat ----
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_idle("idle10");
    end

    // ---- B4 LSB-first: 00 01 11 10 ----
    PAR_IN = 8'hB4; MSB_FIRST = 1'b0; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0; PAR_IN = 8'h00; MSB_FIRST = 1'b1;
    chk_beat("lsb_b0", 2'b00, 1'b1);
    tick(); chk_beat("lsb_b1", 2'b01, 1'b0);
    tick(); chk_beat("lsb_b2", 2'b11, 1'b0);
    tick(); chk_beat("lsb_b3", 2'b10, 1'b0);
`ifdef GEARBOX_SER_PARITY_EN
    // lane XOR of 00,01,11,10 = 00
    tick(); chk_beat("lsb_par", 2'b00, 1'b0);
`endif
    tick(); chk_idle("lsb_end");

    // ---- back-to-back B4 then A7, MSB-first ----
    PAR_IN = 8'hB4; MSB_FIRST = 1'b1; IN_VALID = 1'b1;
    tick();
    chk_beat("b2b_w0b0", 2'b10, 1'b1);
    chk("b2b_ready0", {31'b0, IN_READY}, 32'd1);
    PAR_IN = 8'hA7;
    tick();
    IN_VALID = 1'b0; PAR_IN = 8'h00;
    chk_beat("b2b_w0b1", 2'b11, 1'b0);
    chk("b2b_ready1", {31'b0, IN_READY}, 32'd0);
    tick(); chk_beat("b2b_w0b2", 2'b01, 1'b0);
    chk("b2b_ready2", {31'b0, IN_READY}, 32'd0);
    tick(); chk_beat("b2b_w0b3", 2'b00, 1'b0);
    chk("b2b_ready3", {31'b0, IN_READY}, 32'd0);
`ifdef GEARBOX_SER_PARITY_EN
    tick(); chk_beat("b2b_w0par", 2'b00, 1'b0);
    chk("b2b_readyp", {31'b0, IN_READY}, 32'd0);
`endif
    tick(); chk_beat("b2b_w1b0", 2'b10, 1'b1);
    chk("b2b_ready4", {31'b0, IN_READY}, 32'd1);
    tick(); chk_beat("b2b_w1b1", 2'b10, 1'b0);
    tick(); chk_beat("b2b_w1b2", 2'b01, 1'b0);
    tick(); chk_beat("b2b_w1b3", 2'b11, 1'b0);
`ifdef GEARBOX_SER_PARITY_EN
    tick(); chk_beat("b2b_w1par", 2'b10, 1'b0);
`endif
    tick(); chk_idle("b2b_end");

    // ---- reset pulsed during beat 2 ----
    PAR_IN = 8'hB4; MSB_FIRST = 1'b1; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk_beat("rp_b0", 2'b10, 1'b1);
    tick(); chk_beat("rp_b1", 2'b11, 1'b0);
    tick(); chk_beat("rp_b2", 2'b01, 1'b0);
    #2;
    RESET_N = 1'b0;
    #1;
    chk_idle("rp_async");
    chk("rp_ready", {31'b0, IN_READY}, 32'd1);
    tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle("rp_discard");
    end

    // ---- accept on the first edge after reset release ----
    RESET_N = 1'b0;
    tick();
    chk_idle("rp2_rst");
    RESET_N = 1'b1; PAR_IN = 8'hA7; MSB_FIRST = 1'b1; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    chk_beat("first_b0", 2'b10, 1'b1);
    tick(); chk_beat("first_b1", 2'b10, 1'b0);
    tick(); chk_beat("first_b2", 2'b01, 1'b0);
    tick(); chk_beat("first_b3", 2'b11, 1'b0);
`ifdef GEARBOX_SER_PARITY_EN
    tick(); chk_beat("first_par", 2'b10, 1'b0);
`endif
    tick(); chk_idle("first_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
